// File: rtl/pc_sequencer.sv
// Next-PC selector: priority chain of trap/branch/jump/stall/increment with a post-redirect flush window.
// Optional trap support is enabled by defining PC_TRAP_EN; otherwise TrapReq is ignored and EPC reads 0.
module pc_sequencer #(
  parameter int unsigned BITS_SIZE    = 32,
  parameter int unsigned INC          = 4,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0080,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic [BITS_SIZE-1:0] PCResult,
  input  logic                 Stall,
  input  logic                 BranchReq,
  input  logic [BITS_SIZE-1:0] BranchTarget,
  input  logic                 JumpReq,
  input  logic [BITS_SIZE-1:0] JumpTarget,
  input  logic                 TrapReq,
  output logic [BITS_SIZE-1:0] PCNext,
  output logic                 Flush,
  output logic [BITS_SIZE-1:0] EPC,
  output logic [1:0]           State
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  localparam logic [BITS_SIZE-1:0] INC_V     = BITS_SIZE'(INC);
  localparam logic [BITS_SIZE-1:0] TRAP_V    = BITS_SIZE'(TRAP_VECTOR);
  localparam logic [3:0]           FLUSH_LEN = 4'(FLUSH_CYCLES);

  state_t     state_q, state_d;
  logic [3:0] fcnt_q, fcnt_d;
  logic       flush_q;
  logic       in_flush;
  logic       trap_hit, branch_hit, jump_hit, redirect;

  assign in_flush = (state_q == ST_FLUSH);

`ifdef PC_TRAP_EN
  assign trap_hit = TrapReq & ~in_flush;
`else
  logic unused_trap;
  assign unused_trap = TrapReq;
  assign trap_hit    = 1'b0;
`endif

  // Requests during FLUSH come from the wrong path and are dropped entirely.
  assign branch_hit = BranchReq & ~in_flush & ~trap_hit;
  assign jump_hit   = JumpReq & ~in_flush & ~trap_hit & ~BranchReq;
  assign redirect   = trap_hit | branch_hit | jump_hit;

  always_comb begin
    PCNext = PCResult + INC_V;
    if (Reset)           PCNext = '0;
    else if (trap_hit)   PCNext = TRAP_V;
    else if (branch_hit) PCNext = BranchTarget;
    else if (jump_hit)   PCNext = JumpTarget;
    else if (Stall)      PCNext = PCResult;
  end

  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    case (state_q)
      ST_RUN, ST_STALL: begin
        if (redirect) begin
          state_d = ST_FLUSH;
          fcnt_d  = FLUSH_LEN;
        end else begin
          state_d = Stall ? ST_STALL : ST_RUN;
        end
      end
      ST_FLUSH: begin
        if (!Stall) begin
          if (fcnt_q <= 4'd1) begin
            state_d = ST_RUN;
            fcnt_d  = '0;
          end else begin
            fcnt_d = fcnt_q - 4'd1;
          end
        end
      end
      default: begin
        state_d = ST_RUN;
        fcnt_d  = '0;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= ST_RUN;
      fcnt_q  <= '0;
      flush_q <= 1'b0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      flush_q <= (state_d == ST_FLUSH);
    end
  end

`ifdef PC_TRAP_EN
  logic [BITS_SIZE-1:0] epc_q;

  always_ff @(posedge Clk) begin
    if (Reset)         epc_q <= '0;
    else if (trap_hit) epc_q <= PCResult;
  end

  assign EPC = epc_q;
`else
  assign EPC = '0;
`endif

  assign Flush = flush_q;
  assign State = state_q;

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Next-address controller for the program counter register. Each cycle it selects the PC's next value from a strict-priority set of requesters: trap, branch, jump, stall hold, and sequential increment. After any redirect it runs a fixed-length flush window that squashes wrong-path fetches. It sits between the PC register output, the branch/jump resolution logic and the fetch stage, and drives the PC register's next-value input.

## Interface
- BITS_SIZE, 32, address width.
- INC, 4, sequential increment in bytes.
- TRAP_VECTOR, 32'h0000_0080, trap handler address, truncated to BITS_SIZE.
- FLUSH_CYCLES, 2, post-redirect squash length, range 1..15.

- Clk  in  1  clock.
- Reset  in  1  reset, synchronous, active-high.
- PCResult  in  BITS_SIZE  current PC register value.
- Stall  in  1  hold PC (pipeline backpressure).
- BranchReq  in  1  taken-branch redirect request.
- BranchTarget  in  BITS_SIZE  branch destination.
- JumpReq  in  1  jump redirect request.
- JumpTarget  in  BITS_SIZE  jump destination.
- TrapReq  in  1  trap request; ignored unless PC_TRAP_EN is defined.
- PCNext  out  BITS_SIZE  next PC value; combinational.
- Flush  out  1  registered; squash the fetch currently in flight.
- EPC  out  BITS_SIZE  registered PC captured at trap acceptance.
- State  out  2  registered FSM state; RUN=0, STALL=1, FLUSH=2.

## Operation
- FSM states: RUN, STALL, FLUSH. There is also a 4-bit flush counter, FCnt.
- PCNext selection in RUN or STALL, highest priority first:
  - Reset → 0.
  - TrapReq → TRAP_VECTOR.
  - BranchReq → BranchTarget.
  - JumpReq → JumpTarget.
  - Stall → PCResult.
  - otherwise → PCResult + INC.
- Increment wraps modulo 2^BITS_SIZE; there is no carry out.
- Redirect = an accepted trap, branch or jump.
- On a redirect: next state is FLUSH, FCnt <= FLUSH_CYCLES, and Flush is 1 on the following cycle.
- A redirect beats Stall. A stalled branch still redirects.
- RUN → STALL when Stall=1 and there is no redirect. STALL → RUN when Stall=0 and there is no redirect.
- In FLUSH, Trap/Branch/Jump requests are ignored (they come from the wrong path).
- In FLUSH, PCNext = PCResult when Stall=1, else PCResult + INC.
- In FLUSH, FCnt decrements only when Stall=0. Flush stays 1 throughout FLUSH.
- FLUSH exit: when FCnt=1 and Stall=0, next state is RUN and Flush goes to 0.
- Trap acceptance: EPC <= PCResult. EPC is otherwise held.

## Timing
- PCNext is a zero-latency combinational function of inputs, state and Reset.
- The PC register observes a redirect target on the next Clk edge.
- Flush rises one cycle after the redirect cycle. It stays high FLUSH_CYCLES unstalled cycles, plus any stall cycles.
- Reset values: State=RUN, FCnt=0, Flush=0, EPC=0. PCNext=0 while Reset=1.
- Reset mid-FLUSH aborts the flush at the next edge. No pending redirect is retained.
- Simultaneous requests: only the highest priority is taken. Lower ones are dropped, not queued.

## Configuration
- PC_TRAP_EN defined:
  - TrapReq participates in the priority chain.
  - EPC captures the PC on trap acceptance.
- PC_TRAP_EN undefined:
  - TrapReq is ignored.
  - No EPC register is built; EPC is tied to 0.
  - The chain starts at BranchReq.

## Test plan
- Sequential run: Reset 1 cycle, then idle, with PCNext fed back into a PC register. PC goes 0, 4, 8, 12. State=RUN and Flush=0 throughout.
- Stall: at PC=8, Stall=1 for 3 cycles. PC holds 8 for 3 cycles and State=STALL. On release the PC resumes at 12.
- Branch + flush: at PC=12, BranchReq=1 with BranchTarget=0x40, and FLUSH_CYCLES=2.
  - Next PC=0x40.
  - Flush=1 for 2 cycles, with JumpReq=1 (JumpTarget=0x100) asserted during FLUSH.
  - The jump is ignored; the PC goes 0x44 then 0x48.
- Priority: BranchReq, JumpReq and Stall asserted together. PCNext=BranchTarget.
- Trap (PC_TRAP_EN defined): at PC=0x20, TrapReq and BranchReq asserted together. PCNext=0x80, EPC=0x20 and FLUSH is entered. With the macro undefined, PCNext is the branch target and EPC=0.
- Reset mid-flush: Reset during FLUSH with FCnt=2. The next cycle has State=RUN, Flush=0 and PC=0.
